// File: rtl/coin_pulse_tx.sv
// Coin pulse transmitter: emits up to three coin pulses on m_out, then an
// optional accept pulse on a_out, and reports completion with a done strobe.
// Every output is registered from the next-state value.
module coin_pulse_tx #(
   parameter int unsigned HIGH_CYC = 4,
   parameter int unsigned LOW_CYC  = 4,
   parameter int unsigned A_CYC    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_coins,
   input  logic       req_accept,
   output logic       req_ready,
   input  logic       abort,
   output logic       m_out,
   output logic       a_out,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [1:0] coins_sent
);

   typedef enum logic [2:0] {StIdle, StHigh, StLow, StAccept, StDone} state_e;

   // The phase counter is loaded with (width - 1) and counts down to zero.
   localparam logic [7:0] HighLoad = 8'(HIGH_CYC - 1);
   localparam logic [7:0] LowLoad  = 8'(LOW_CYC - 1);
   localparam logic [7:0] AccLoad  = 8'(A_CYC - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] left_q, left_d;
   logic       acc_q, acc_d;
   logic [1:0] sent_q, sent_d;
   logic       aborted_q, aborted_d;
   logic       m_q, a_q, busy_q, done_q, ready_q;

   // Next-state, phase-counter and status logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      acc_d     = acc_q;
      sent_d    = sent_q;
      aborted_d = aborted_q;
      unique case (state_q)
         StIdle: begin
            // abort is ignored here; a request always wins
            if (req_valid) begin
               acc_d     = req_accept;
               left_d    = req_coins;
               sent_d    = 2'd0;
               aborted_d = 1'b0;
               if (req_coins != 2'd0) begin
                  state_d = StHigh;
                  cnt_d   = HighLoad;
               end else if (req_accept) begin
                  state_d = StAccept;
                  cnt_d   = AccLoad;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StHigh: begin
            if (abort) begin
               // truncated pulse is not counted
               state_d   = StDone;
               aborted_d = 1'b1;
            end else if (cnt_q == 8'd0) begin
               state_d = StLow;
               cnt_d   = LowLoad;
               sent_d  = sent_q + 2'd1;
               left_d  = left_q - 2'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StLow: begin
            if (abort) begin
               state_d   = StDone;
               aborted_d = 1'b1;
            end else if (cnt_q == 8'd0) begin
               if (left_q != 2'd0) begin
                  state_d = StHigh;
                  cnt_d   = HighLoad;
               end else if (acc_q) begin
                  state_d = StAccept;
                  cnt_d   = AccLoad;
               end else begin
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StAccept: begin
            if (abort) begin
               state_d   = StDone;
               aborted_d = 1'b1;
            end else if (cnt_q == 8'd0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered outputs, decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 8'd0;
         left_q    <= 2'd0;
         acc_q     <= 1'b0;
         sent_q    <= 2'd0;
         aborted_q <= 1'b0;
         m_q       <= 1'b0;
         a_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         acc_q     <= acc_d;
         sent_q    <= sent_d;
         aborted_q <= aborted_d;
         m_q       <= (state_d == StHigh);
         a_q       <= (state_d == StAccept);
         busy_q    <= (state_d != StIdle);
         done_q    <= (state_d == StDone);
         ready_q   <= (state_d == StIdle);
      end
   end

   assign m_out      = m_q;
   assign a_out      = a_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign req_ready  = ready_q;
   assign aborted    = aborted_q;
   assign coins_sent = sent_q;

endmodule

// File: tb/tb_coin_pulse_tx.sv
// Directed bench for coin_pulse_tx with default parameters. Outputs are
// sampled on the falling edge; index i of a capture is cycle t+i where the
// request was taken in cycle t.
module tb_coin_pulse_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_coins = 2'd0;
   logic       req_accept = 1'b0;
   logic       req_ready;
   logic       abort = 1'b0;
   logic       m_out, a_out, busy, done, aborted;
   logic [1:0] coins_sent;

   int n_checks = 0;
   int n_errs   = 0;

   logic [63:0] m_vec, a_vec, d_vec;
   logic [1:0]  cs_h [64];
   logic        ab_h [64];
   logic        rdy_h [64];
   logic        busy_h [64];
   int          deb_edges;

   coin_pulse_tx #(
      .HIGH_CYC(4),
      .LOW_CYC (4),
      .A_CYC   (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_coins (req_coins),
      .req_accept(req_accept),
      .req_ready (req_ready),
      .abort     (abort),
      .m_out     (m_out),
      .a_out     (a_out),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .coins_sent(coins_sent)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] span(input int lo, input int hi);
      logic [63:0] v;
      v = '0;
      for (int k = lo; k <= hi; k++) v[k] = 1'b1;
      return v;
   endfunction

   // Present a request in the current (IDLE) cycle t.
   task automatic start(input logic [1:0] coins, input logic acc);
      check("ready_at_take", {63'd0, req_ready}, 64'd1);
      req_valid  = 1'b1;
      req_coins  = coins;
      req_accept = acc;
   endtask

   // Record n cycles; abort is high during cycle abort_at; req_valid stays
   // high while i < hold_until. Also runs a 3-sample debouncer on m_out.
   task automatic capture(input int n, input int abort_at, input int hold_until);
      logic [2:0] sh;
      logic       deb;
      sh = 3'b000;
      deb = 1'b0;
      deb_edges = 0;
      m_vec = '0;
      a_vec = '0;
      d_vec = '0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         m_vec[i]  = m_out;
         a_vec[i]  = a_out;
         d_vec[i]  = done;
         cs_h[i]   = coins_sent;
         ab_h[i]   = aborted;
         rdy_h[i]  = req_ready;
         busy_h[i] = busy;
         sh = {sh[1:0], m_out};
         if (sh == 3'b111 && !deb) begin
            deb = 1'b1;
            deb_edges++;
         end else if (sh == 3'b000) begin
            deb = 1'b0;
         end
         req_valid = (i < hold_until);
         abort     = (i == abort_at);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_m", {63'd0, m_out}, 64'd0);
      check("rst_a", {63'd0, a_out}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_cs", {62'd0, coins_sent}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd1);

      // Two coins, no accept
      start(2'd2, 1'b0);
      capture(18, 0, 0);
      check("t1_m", m_vec, span(1, 4) | span(9, 12));
      check("t1_a", a_vec, 64'd0);
      check("t1_done", d_vec, span(17, 17));
      check("t1_cs4", {62'd0, cs_h[4]}, 64'd0);
      check("t1_cs5", {62'd0, cs_h[5]}, 64'd1);
      check("t1_cs17", {62'd0, cs_h[17]}, 64'd2);
      check("t1_ab17", {63'd0, ab_h[17]}, 64'd0);
      check("t1_busy1", {63'd0, busy_h[1]}, 64'd1);

      // Three coins plus accept
      start(2'd3, 1'b1);
      capture(28, 0, 0);
      check("t2_m", m_vec, span(1, 4) | span(9, 12) | span(17, 20));
      check("t2_a", a_vec, span(25, 26));
      check("t2_done", d_vec, span(27, 27));
      check("t2_overlap", m_vec & a_vec, 64'd0);
      check("t2_cs27", {62'd0, cs_h[27]}, 64'd3);
      check("t2_rdy27", {63'd0, rdy_h[27]}, 64'd0);
      check("t2_rdy28", {63'd0, rdy_h[28]}, 64'd1);

      // Abort during second HIGH cycle of coin 2
      start(2'd3, 1'b0);
      capture(12, 10, 0);
      check("t4_m", m_vec, span(1, 4) | span(9, 10));
      check("t4_a", a_vec, 64'd0);
      check("t4_done", d_vec, span(11, 11));
      check("t4_ab11", {63'd0, ab_h[11]}, 64'd1);
      check("t4_cs11", {62'd0, cs_h[11]}, 64'd1);

      // Abort while idle is ignored
      abort = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_abort_busy", {63'd0, busy}, 64'd0);
      check("idle_abort_done", {63'd0, done}, 64'd0);

      // Empty request taken together with abort
      start(2'd0, 1'b0);
      capture(2, 0, 0);
      check("t3_done", d_vec, span(1, 1));
      check("t3_m", m_vec | a_vec, 64'd0);
      check("t3_cs1", {62'd0, cs_h[1]}, 64'd0);
      check("t3_ab1", {63'd0, ab_h[1]}, 64'd0);

      // Accept only
      start(2'd0, 1'b1);
      capture(4, 0, 0);
      check("acc_a", a_vec, span(1, 2));
      check("acc_m", m_vec, 64'd0);
      check("acc_done", d_vec, span(3, 3));

      // Reset during ACCEPT
      start(2'd0, 1'b1);
      capture(1, 0, 0);
      check("t5_a1", a_vec, span(1, 1));
      #1 rst = 1'b1;
      #1;
      check("t5_a_drop", {63'd0, a_out}, 64'd0);
      check("t5_busy_drop", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      capture(5, 0, 0);
      check("t5_no_done", d_vec, 64'd0);
      check("t5_rdy1", {63'd0, rdy_h[1]}, 64'd1);

      // Back-to-back single-coin requests with req_valid held
      start(2'd1, 1'b0);
      capture(20, 0, 19);
      check("t6_m", m_vec, span(1, 4) | span(11, 14));
      check("t6_done", d_vec, span(9, 9) | span(19, 19));
      check("t6_rdy10", {63'd0, rdy_h[10]}, 64'd1);
      check("t6_cs19", {62'd0, cs_h[19]}, 64'd1);
      check("t6_deb_edges", 64'(deb_edges), 64'd2);
      check("t6_busy20", {63'd0, busy_h[20]}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
